permutation_fsm: RTL and testbench



---
 rtl/permutation_fsm_if.sv | 22 ++
 rtl/permutation_fsm.sv | 111 +++++++++++
 tb/tb_permutation_fsm.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/permutation_fsm_if.sv
// rtl/permutation_fsm_if.sv - launch/result bundle between the mode controller and the permutation engine
interface permutation_fsm_if;
  logic             start_i;     // launch request, sampled only while idle
  logic             rounds12_i;  // 1 = p^a (12 rounds), 0 = p^b (6 rounds)
  logic [4:0][63:0] state_i;     // state loaded on accepted start, word 0 = x0
  logic [4:0][63:0] state_o;     // current state register
  logic             busy_o;      // rounds executing
  logic             done_o;      // one-cycle pulse, state_o holds the result
  logic [3:0]       round_o;     // current round index

  // Mode controller side: issues launches, observes the result.
  modport master (
    output start_i, rounds12_i, state_i,
    input  state_o, busy_o, done_o, round_o
  );

  // Permutation engine side.
  modport slave (
    input  start_i, rounds12_i, state_i,
    output state_o, busy_o, done_o, round_o
  );
endinterface

// File: rtl/permutation_fsm.sv
// rtl/permutation_fsm.sv - iterative ASCON permutation, one round per clock, p^a or p^b
module permutation_fsm (
  input  logic               clock_i,
  input  logic               resetb_i,
  permutation_fsm_if.slave   bus
);

  typedef enum logic {IDLE, RUN} fsm_e;

  fsm_e             fsm_q;
  logic [4:0][63:0] state_q;
  logic [4:0][63:0] state_d;
  logic [3:0]       round_q;
  logic             busy_q;
  logic             done_q;

  logic [4:0][63:0] pc_s;
  logic [4:0][63:0] ps_s;
  logic [4:0]       col_in;
  logic [4:0]       col_out;

  // 5-bit ASCON substitution box, input/output {x0,x1,x2,x3,x4} MSB first.
  function automatic logic [4:0] sbox5(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h04; 5'h01: y = 5'h0b; 5'h02: y = 5'h1f; 5'h03: y = 5'h14;
      5'h04: y = 5'h1a; 5'h05: y = 5'h15; 5'h06: y = 5'h09; 5'h07: y = 5'h02;
      5'h08: y = 5'h1b; 5'h09: y = 5'h05; 5'h0a: y = 5'h08; 5'h0b: y = 5'h12;
      5'h0c: y = 5'h1d; 5'h0d: y = 5'h03; 5'h0e: y = 5'h06; 5'h0f: y = 5'h1c;
      5'h10: y = 5'h1e; 5'h11: y = 5'h13; 5'h12: y = 5'h07; 5'h13: y = 5'h0e;
      5'h14: y = 5'h00; 5'h15: y = 5'h0d; 5'h16: y = 5'h11; 5'h17: y = 5'h18;
      5'h18: y = 5'h10; 5'h19: y = 5'h0c; 5'h1a: y = 5'h01; 5'h1b: y = 5'h19;
      5'h1c: y = 5'h16; 5'h1d: y = 5'h0a; 5'h1e: y = 5'h0f; default: y = 5'h17;
    endcase
    return y;
  endfunction

  // 64-bit rotate right; amounts are always nonzero so (0 - n) mod 64 is the left shift.
  function automatic logic [63:0] ror(input logic [63:0] v, input logic [5:0] n);
    return (v >> n) | (v << (6'd0 - n));
  endfunction

  // One full round of the current register: constant addition, substitution, diffusion.
  always_comb begin
    pc_s = state_q;
    pc_s[2][7:0] = state_q[2][7:0] ^ {~round_q, round_q};

    ps_s    = '0;
    col_in  = '0;
    col_out = '0;
    for (int i = 0; i < 64; i++) begin
      col_in  = {pc_s[0][i], pc_s[1][i], pc_s[2][i], pc_s[3][i], pc_s[4][i]};
      col_out = sbox5(col_in);
      ps_s[0][i] = col_out[4];
      ps_s[1][i] = col_out[3];
      ps_s[2][i] = col_out[2];
      ps_s[3][i] = col_out[1];
      ps_s[4][i] = col_out[0];
    end

    state_d[0] = ps_s[0] ^ ror(ps_s[0], 6'd19) ^ ror(ps_s[0], 6'd28);
    state_d[1] = ps_s[1] ^ ror(ps_s[1], 6'd61) ^ ror(ps_s[1], 6'd39);
    state_d[2] = ps_s[2] ^ ror(ps_s[2], 6'd1)  ^ ror(ps_s[2], 6'd6);
    state_d[3] = ps_s[3] ^ ror(ps_s[3], 6'd10) ^ ror(ps_s[3], 6'd17);
    state_d[4] = ps_s[4] ^ ror(ps_s[4], 6'd7)  ^ ror(ps_s[4], 6'd41);
  end

  // Control FSM: load on start while idle, iterate to round 11, pulse done on the way back to idle.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (bus.start_i) begin
            state_q <= bus.state_i;
            round_q <= bus.rounds12_i ? 4'd0 : 4'd6;
            busy_q  <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= state_d;
          if (round_q == 4'd11) begin
            round_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fsm_q   <= IDLE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.state_o = state_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.round_o = round_q;

  // The round counter stops at 11; 12..15 must never appear.
  round_range_a: assert property (@(posedge clock_i) disable iff (!resetb_i) round_q < 4'd12);

endmodule

// File: tb/tb_permutation_fsm.sv
// tb/tb_permutation_fsm.sv - randomized scoreboard bench for permutation_fsm
module tb_permutation_fsm;

  typedef logic [4:0][63:0] st_t;
  typedef struct {
    st_t result;
    int  done_cyc;
  } sb_entry_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   pass_cnt;
  int   total_cnt;
  sb_entry_t sb_q[$];
  st_t  last_result;
  st_t  iv;

  permutation_fsm_if bus ();

  permutation_fsm dut (
    .clock_i  (clk),
    .resetb_i (rstn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference round in the usual bitsliced software form.
  function automatic st_t model_round(input st_t s, input int r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    st_t o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ 64'(((15 - r) << 4) | r);
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    o[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    o[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    o[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    o[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    o[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return o;
  endfunction

  function automatic st_t model_perm(input st_t s, input int first);
    st_t t;
    t = s;
    for (int r = first; r < 12; r++) t = model_round(t, r);
    return t;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  // Monitor: every done pulse must match the oldest pending launch, on the predicted cycle.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (rstn && bus.done_o) begin
        if (sb_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_done: got done_o=1 expected no pending permutation at cycle %0d", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("result", bus.state_o, e.result);
          chk("latency", cyc, e.done_cyc);
        end
      end
    end
  end

  // Called at a falling edge; launches one permutation and follows it to its done cycle.
  task automatic do_perm(input st_t st, input bit r12, input bit hold, input bit keep);
    int first;
    int n;
    first = r12 ? 0 : 6;
    n     = r12 ? 12 : 6;
    bus.start_i    = 1'b1;
    bus.rounds12_i = r12;
    bus.state_i    = st;
    sb_q.push_back('{model_perm(st, first), cyc + 1 + n});
    @(negedge clk);
    chk("load_state", bus.state_o, st);
    chk("busy_run", bus.busy_o, 1);
    chk("round_first", bus.round_o, first);
    bus.state_i    = rand_state();
    bus.rounds12_i = ~r12;
    if (!hold) bus.start_i = 1'b0;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      chk("round_step", bus.round_o, first + k);
      if (k == 1) chk("single_round", bus.state_o, model_round(st, first));
    end
    @(negedge clk);
    chk("done_pulse", bus.done_o, 1);
    chk("busy_end", bus.busy_o, 0);
    chk("round_end", bus.round_o, 0);
    last_result = model_perm(st, first);
    if (!keep) bus.start_i = 1'b0;
  endtask

  initial begin
    bit r12, hold, chain;
    pass_cnt = 0;
    total_cnt = 0;
    rstn = 1'b0;
    bus.start_i = 1'b0;
    bus.rounds12_i = 1'b0;
    bus.state_i = '0;
    iv[0] = 64'h80400c0600000000;
    iv[1] = 64'h0001020304050607;
    iv[2] = 64'h08090a0b0c0d0e0f;
    iv[3] = 64'h0001020304050607;
    iv[4] = 64'h08090a0b0c0d0e0f;

    #12;
    chk("reset_state", bus.state_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_done", bus.done_o, 0);
    chk("reset_round", bus.round_o, 0);
    @(negedge clk);
    rstn = 1'b1;

    do_perm(iv, 1'b1, 1'b0, 1'b0);
    do_perm(iv, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_state", bus.state_o, last_result);
      chk("idle_done", bus.done_o, 0);
    end

    // Start held through the run, then a restart in the done cycle.
    do_perm(iv, 1'b1, 1'b1, 1'b1);
    do_perm(rand_state(), 1'b1, 1'b0, 1'b0);

    // Reset asynchronously in the middle of round 5.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.rounds12_i = 1'b1;
    bus.state_i = rand_state();
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_round", bus.round_o, 5);
    #2 rstn = 1'b0;
    #1;
    chk("async_state", bus.state_o, 0);
    chk("async_busy", bus.busy_o, 0);
    chk("async_done", bus.done_o, 0);
    chk("async_round", bus.round_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    do_perm(rand_state(), 1'b1, 1'b0, 1'b0);

    // Randomized launches, some held, some back-to-back.
    for (int i = 0; i < 10; i++) begin
      r12   = 1'($urandom());
      hold  = 1'($urandom());
      chain = (i < 9) ? 1'($urandom()) : 1'b0;
      do_perm(rand_state(), r12, hold, chain);
      if (!chain) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("pending_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
